// File: rtl/combiner_arbiter.sv
// Packet-level round-robin arbiter for the shared combiner output.
// Grants one stream per packet and strobes its buffer once per word until the packet drains.
//
// state | meaning
// IDLE  | no packet in flight; arbitrate among streams with a legal-length request
// SEND  | granted packet draining; one rd per cycle with out_ready, last on the final word
module combiner_arbiter #(
    parameter int N_STREAMS         = 2,
    parameter int LOG_N_STREAMS     = 1,
    parameter int MSG_LENGTH_WIDTH  = 8,
    parameter int MAX_PACKET_LENGTH = 16
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [N_STREAMS-1:0]                  req,
    input  logic [N_STREAMS*MSG_LENGTH_WIDTH-1:0] length,
    input  logic                                  out_ready,
    output logic [N_STREAMS-1:0]                  grant,
    output logic [N_STREAMS-1:0]                  rd,
    output logic                                  last,
    output logic                                  busy,
    output logic                                  error
);

    typedef enum logic {IDLE, SEND} state_t;

    localparam logic [MSG_LENGTH_WIDTH-1:0] MAX_LEN = MSG_LENGTH_WIDTH'(MAX_PACKET_LENGTH);
    localparam logic [MSG_LENGTH_WIDTH-1:0] ONE_LEN = MSG_LENGTH_WIDTH'(1);

    state_t                      state_q, state_d;
    logic [LOG_N_STREAMS-1:0]    ptr_q, ptr_d;
    logic [MSG_LENGTH_WIDTH-1:0] remaining_q, remaining_d;
    logic [N_STREAMS-1:0]        grant_q, grant_d;
    logic                        error_q, error_d;

    logic [N_STREAMS-1:0]        legal;
    logic [N_STREAMS-1:0]        elig;
    logic                        hi_found, lo_found;
    logic [LOG_N_STREAMS-1:0]    hi_idx, lo_idx, sel_idx;
    logic [MSG_LENGTH_WIDTH-1:0] sel_len;

    always_comb begin
        legal = '0;
        for (int i = 0; i < N_STREAMS; i++) begin
            legal[i] = (length[i*MSG_LENGTH_WIDTH +: MSG_LENGTH_WIDTH] != '0) &&
                       (length[i*MSG_LENGTH_WIDTH +: MSG_LENGTH_WIDTH] <= MAX_LEN);
        end
        elig = req & legal;
    end

    // Round robin: first eligible stream above ptr, otherwise wrap to the lowest eligible one.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = 0; i < N_STREAMS; i++) begin
            if (elig[i] && (LOG_N_STREAMS'(i) > ptr_q) && !hi_found) begin
                hi_found = 1'b1;
                hi_idx   = LOG_N_STREAMS'(i);
            end
            if (elig[i] && !lo_found) begin
                lo_found = 1'b1;
                lo_idx   = LOG_N_STREAMS'(i);
            end
        end
        sel_idx = hi_found ? hi_idx : lo_idx;
        sel_len = '0;
        for (int i = 0; i < N_STREAMS; i++) begin
            if (LOG_N_STREAMS'(i) == sel_idx) begin
                sel_len = length[i*MSG_LENGTH_WIDTH +: MSG_LENGTH_WIDTH];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        remaining_d = remaining_q;
        grant_d     = grant_q;
        error_d     = error_q;
        case (state_q)
            IDLE: begin
                grant_d = '0;
                error_d = error_q | (|(req & ~legal));
                if (|elig) begin
                    grant_d     = N_STREAMS'(1) << sel_idx;
                    remaining_d = sel_len;
                    ptr_d       = sel_idx;
                    state_d     = SEND;
                end
            end
            SEND: begin
                if (out_ready) begin
                    remaining_d = remaining_q - ONE_LEN;
                    if (remaining_q == ONE_LEN) begin
                        grant_d = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= LOG_N_STREAMS'(N_STREAMS - 1);
            remaining_q <= '0;
            grant_q     <= '0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            remaining_q <= remaining_d;
            grant_q     <= grant_d;
            error_q     <= error_d;
        end
    end

    assign busy  = (state_q == SEND);
    assign grant = grant_q;
    assign rd    = (busy && out_ready) ? grant_q : '0;
    assign last  = busy && out_ready && (remaining_q == ONE_LEN);
    assign error = error_q;

endmodule

// File: doc/combiner_arbiter.md
# combiner_arbiter

Packet-level round-robin scheduler for the shared output of `message_stream_combiner`. Each of `N_STREAMS` input buffers raises a request once it holds a complete packet and presents that packet's length. The arbiter grants one stream at a time and drives that buffer's read strobe once per output word until the whole packet has drained. Packets are never interleaved; header and body always leave contiguously.

## Interface

Parameters:
- `N_STREAMS`, 2: number of requesting streams.
- `LOG_N_STREAMS`, 1: width of the internal stream pointer.
- `MSG_LENGTH_WIDTH`, 8: width of each length field.
- `MAX_PACKET_LENGTH`, 16: largest legal packet length in words, header included.

Ports:
- `clk`, input, 1: clock; all logic is on the rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `req`, input, `N_STREAMS`: bit i high means stream i holds at least one complete packet.
- `length`, input, `N_STREAMS*MSG_LENGTH_WIDTH`: word count of stream i's head packet, in slice i (stream 0 at the LSBs). Valid while `req[i]` is high.
- `out_ready`, input, 1: downstream can accept a word this cycle.
- `grant`, output, `N_STREAMS`: one-hot registered grant; all-zero when idle.
- `rd`, output, `N_STREAMS`: one-hot read strobe to the buffers, equal to `grant & {N{out_ready}}` in SEND.
- `last`, output, 1: high together with `rd` on the final word of a packet.
- `busy`, output, 1: high in SEND.
- `error`, output, 1: sticky; set by a request carrying an illegal length, cleared only by `reset`.

## Operation

Two-state FSM: IDLE and SEND.

**Registers**
- Stream pointer `ptr` holds the last-served stream. Its reset value is `N_STREAMS-1`, so stream 0 has first priority after reset.
- Down-counter `remaining` is `MSG_LENGTH_WIDTH` bits wide.

**IDLE**
- Eligible mask = `req` AND (`length[i]` in 1..`MAX_PACKET_LENGTH`).
- If any `req[i]` has length 0 or greater than `MAX_PACKET_LENGTH`, set `error`. That stream is excluded from arbitration and is never granted.
- If the mask is non-zero:
  - Select the first eligible stream scanning `ptr+1`, `ptr+2`, … modulo `N_STREAMS`.
  - Register `grant` one-hot for that stream and load `remaining` with its length.
  - Set `ptr` to the selected stream and go to SEND.
- If the mask is zero, stay in IDLE with `grant` = 0.

**SEND**
- `rd` = `grant` when `out_ready` = 1, otherwise 0.
- Each cycle with `out_ready` = 1, decrement `remaining`.
- When `remaining` = 1 and `out_ready` = 1:
  - Assert `last`.
  - Clear `grant` on the next edge and return to IDLE.
- `req` and `length` are ignored in SEND. The length was sampled once in IDLE; upstream must not withdraw a granted packet.

**Reset**
- Asserting `reset` at any time immediately forces IDLE and drives `grant`, `rd`, `last`, `busy`, `error`, and `remaining` to 0, with `ptr` = `N_STREAMS-1`.
- A packet cut off mid-stream is abandoned. Buffer recovery is the buffers' own reset.

## Timing

- Reset values: all outputs 0.
- Request-to-first-read latency: a request high at edge t produces `grant` and `busy` from cycle t+1. The first `rd` is in cycle t+1 if `out_ready` is high.
- `rd` and `last` are combinational from registered state and `out_ready`. No other input-to-output combinational path exists.
- One mandatory IDLE cycle separates consecutive packets. A packet of length L with `out_ready` held high occupies L+1 cycles, including the arbitration cycle.
- Simultaneous requests are resolved only by the round-robin order. A stream never receives two consecutive grants while another eligible stream is requesting.
- `out_ready` low in SEND stalls without losing position: `grant` is held and `remaining` is frozen.
- Length exactly `MAX_PACKET_LENGTH` is legal. `MAX_PACKET_LENGTH+1` is an error.

## Test plan

Parameters for all cases: N=2, MAX=16, `out_ready`=1 unless stated.

1. `req`=2'b10 with length 3 from cycle 0 → `grant`=2'b10 in cycles 1–3; `rd[1]` in cycles 1, 2, 3; `last` in cycle 3; `grant`=0 and `busy`=0 in cycle 4.
2. `req`=2'b11 held, both lengths 2 → order s0, s1, s0. `grant`=01 in cycles 1–2, 10 in cycles 4–5, 01 in cycles 7–8.
3. Stream 0, length 4, `out_ready` low in cycles 2–3 → `rd[0]` in cycles 1, 4, 5, 6; `last` in cycle 6; `grant` held through cycle 6.
4. In cycle 0, stream 0 has length 0 and stream 1 has length 1 → `error` rises at cycle 1 and stays high; `grant`=10 in cycle 1 only; stream 0 is never granted.
5. Stream 0, length 5, `reset` pulsed during cycle 3 → `grant`, `rd`, and `busy` go 0 asynchronously. After release, with `req`=11, stream 0 is granted first.
6. Stream 1 with length 16 → exactly 16 `rd[1]` pulses, `last` on the 16th, no error. Repeat with length 17 → `error`=1 and no grant.
